// File: rtl/sdfm_input_seq.sv
// sdfm_input_seq: applies input-mode/divider changes to the ICU at safe points,
// holds the sinc filter in reset while the input settles, and locks onto clock edges.
// Latency: all outputs registered, valid the cycle after the causing state transition.
// Backpressure: cfg_wr is dropped while cfg_busy; no other flow control.
// Build option: define SDFM_INSEQ_AUTORETRY_EN for automatic retry out of FAULT.
module sdfm_input_seq #(
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_EDGES = 16,
  parameter int LOCK_TMO   = 4096,
  parameter int DRAIN_CYC  = 4
) (
  input  logic       SYSRSTn,
  input  logic       SYSCLK,
  input  logic       cfg_en,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_inmod,
  input  logic [3:0] cfg_indiv,
  input  logic       fault_clr,
  input  logic       sd_clk_in,
  input  logic       detect_err,
  output logic [1:0] reg_inmod,
  output logic [3:0] reg_indiv,
  output logic       flt_rstn,
  output logic       flt_en,
  output logic       cfg_busy,
  output logic       irq_fault,
  output logic       fault_sticky,
  output logic [1:0] fault_cause,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_SWITCH = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LOCK   = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [1:0] CAUSE_CLK_LOST = 2'b01;
  localparam logic [1:0] CAUSE_LOCK_TMO = 2'b10;

  // Edge counter is just wide enough to hold LOCK_EDGES itself.
  localparam int EW = $clog2(LOCK_EDGES + 1);

  // Last-cycle markers: the general cycle counter starts at 0 on state entry,
  // so a phase of N cycles ends when the counter reads N-1.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYC - 1);
  localparam logic [EW-1:0] EDGE_TGT  = EW'(LOCK_EDGES);
  localparam logic [16:0] TMO_TGT     = 17'(LOCK_TMO);

  logic [2:0]    nxt;
  logic [1:0]    cause_nxt;
  logic          fault_entry;
  logic          switch_entry;

  logic [1:0]    sh_inmod;
  logic [3:0]    sh_indiv;
  logic          sh_ld;
  logic [1:0]    sh_inmod_nxt;
  logic [3:0]    sh_indiv_nxt;

  logic          prev;
  logic          rise;

  logic [15:0]   cyc_cnt;
  logic [15:0]   cyc_inc;
  logic [15:0]   tmo_cnt;
  logic [15:0]   tmo_inc;
  logic [EW-1:0] edge_cnt;
  logic [EW-1:0] edge_inc;

  logic          lock_ok;
  logic          lock_tmo;
  logic          stay_lock;

`ifdef SDFM_INSEQ_AUTORETRY_EN
  localparam logic [15:0] RETRY_WAIT_LAST = 16'd255;
  logic [1:0]    retry_cnt;
  logic          retry_go;
`endif

  // Shadow accepts a write only while no switch sequence is in flight; the
  // next-value is forwarded so a write coincident with SWITCH entry is applied.
  assign sh_ld        = cfg_wr & ~cfg_busy;
  assign sh_inmod_nxt = sh_ld ? cfg_inmod : sh_inmod;
  assign sh_indiv_nxt = sh_ld ? cfg_indiv : sh_indiv;

  assign rise = sd_clk_in & ~prev;

  // All counters saturate rather than wrap.
  assign cyc_inc  = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
  assign tmo_inc  = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
  assign edge_inc = (edge_cnt == {EW{1'b1}}) ? edge_cnt : edge_cnt + EW'(1);

  // Lock succeeds on the clean edge that brings the count to target; the
  // timeout uses the post-increment value so LOCK lasts exactly LOCK_TMO cycles.
  assign lock_ok  = rise & ~detect_err & (edge_inc >= EDGE_TGT);
  assign lock_tmo = ({1'b0, tmo_inc} >= TMO_TGT);

`ifdef SDFM_INSEQ_AUTORETRY_EN
  assign retry_go = (cyc_cnt >= RETRY_WAIT_LAST) && (retry_cnt != 2'd3);
`endif

  // Next-state decode; priority is channel disable, then fault, then config write.
  always_comb begin
    nxt       = state;
    cause_nxt = 2'b00;
    case (state)
      S_IDLE: begin
        if (cfg_en) nxt = S_SWITCH;
      end
      S_DRAIN: begin
        // Drain always completes so the filter flushes cleanly, even on disable.
        if (cyc_cnt >= DRAIN_LAST) nxt = cfg_en ? S_SWITCH : S_IDLE;
      end
      S_SWITCH: begin
        nxt = cfg_en ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (!cfg_en)                     nxt = S_IDLE;
        else if (cyc_cnt >= SETTLE_LAST) nxt = S_LOCK;
      end
      S_LOCK: begin
        if (!cfg_en) begin
          nxt = S_IDLE;
        end else if (lock_tmo) begin
          nxt       = S_FAULT;
          cause_nxt = CAUSE_LOCK_TMO;
        end else if (lock_ok) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!cfg_en) begin
          nxt = S_DRAIN;
        end else if (detect_err) begin
          nxt       = S_FAULT;
          cause_nxt = CAUSE_CLK_LOST;
        end else if (cfg_wr) begin
          nxt = S_DRAIN;
        end
      end
      S_FAULT: begin
        if (!cfg_en || fault_clr) nxt = S_IDLE;
`ifdef SDFM_INSEQ_AUTORETRY_EN
        else if (retry_go)        nxt = S_SWITCH;
`endif
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign fault_entry  = (nxt == S_FAULT) && (state != S_FAULT);
  assign switch_entry = (nxt == S_SWITCH) && (state != S_SWITCH);
  assign stay_lock    = (state == S_LOCK) && (nxt == S_LOCK);

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state     <= S_IDLE;
      flt_rstn  <= 1'b0;
      flt_en    <= 1'b0;
      cfg_busy  <= 1'b0;
      irq_fault <= 1'b0;
    end else begin
      state     <= nxt;
      flt_rstn  <= (nxt == S_RUN) || (nxt == S_DRAIN);
      flt_en    <= (nxt == S_RUN);
      cfg_busy  <= (nxt == S_DRAIN) || (nxt == S_SWITCH) ||
                   (nxt == S_SETTLE) || (nxt == S_LOCK);
      irq_fault <= fault_entry;
    end
  end

  // Shadow registers capture host writes; applied registers update on SWITCH entry.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      sh_inmod  <= 2'b00;
      sh_indiv  <= 4'd0;
      reg_inmod <= 2'b00;
      reg_indiv <= 4'd0;
    end else begin
      sh_inmod <= sh_inmod_nxt;
      sh_indiv <= sh_indiv_nxt;
      if (switch_entry) begin
        reg_inmod <= sh_inmod_nxt;
        reg_indiv <= sh_indiv_nxt;
      end
    end
  end

  // Fault status: entry sets (and wins over a simultaneous clear), fault_clr clears.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      fault_sticky <= 1'b0;
      fault_cause  <= 2'b00;
    end else if (fault_entry) begin
      fault_sticky <= 1'b1;
      fault_cause  <= cause_nxt;
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
      fault_cause  <= 2'b00;
    end
  end

  // Edge detector history and the per-state cycle counter (cleared on any transition).
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      prev    <= 1'b0;
      cyc_cnt <= 16'd0;
    end else begin
      prev    <= sd_clk_in;
      cyc_cnt <= (nxt != state) ? 16'd0 : cyc_inc;
    end
  end

  // Lock counters run only while remaining in LOCK; clean edges count, errors restart.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      tmo_cnt  <= 16'd0;
      edge_cnt <= {EW{1'b0}};
    end else if (!stay_lock) begin
      tmo_cnt  <= 16'd0;
      edge_cnt <= {EW{1'b0}};
    end else begin
      tmo_cnt <= tmo_inc;
      if (detect_err)  edge_cnt <= {EW{1'b0}};
      else if (rise)   edge_cnt <= edge_inc;
    end
  end

`ifdef SDFM_INSEQ_AUTORETRY_EN
  // Retry budget: consumed on each automatic FAULT->SWITCH, refilled by RUN or IDLE.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      retry_cnt <= 2'd0;
    end else if ((nxt == S_RUN) || (nxt == S_IDLE)) begin
      retry_cnt <= 2'd0;
    end else if ((state == S_FAULT) && (nxt == S_SWITCH) && (retry_cnt != 2'd3)) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdfm_input_seq.sv
// tb_sdfm_input_seq: directed sequence through config, lock, drain, fault and reset paths.
// Expected applied configs and fault causes are queued when driven, popped when observed.
// Inputs change and outputs are sampled 1 time unit after the rising clock edge.
module tb_sdfm_input_seq;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_SWITCH = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LOCK   = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic       SYSRSTn;
  logic       SYSCLK;
  logic       cfg_en;
  logic       cfg_wr;
  logic [1:0] cfg_inmod;
  logic [3:0] cfg_indiv;
  logic       fault_clr;
  logic       sd_clk_in;
  logic       detect_err;
  logic [1:0] reg_inmod;
  logic [3:0] reg_indiv;
  logic       flt_rstn;
  logic       flt_en;
  logic       cfg_busy;
  logic       irq_fault;
  logic       fault_sticky;
  logic [1:0] fault_cause;
  logic [2:0] state;

  typedef struct packed {
    logic [1:0] inmod;
    logic [3:0] indiv;
  } cfg_t;

  cfg_t       cfg_q[$];
  logic [1:0] cause_q[$];

  int checks   = 0;
  int failures = 0;
  int clk_on   = 0;
  int ph       = 0;
  int lock_edges = 0;

  sdfm_input_seq dut (
    .SYSRSTn      (SYSRSTn),
    .SYSCLK       (SYSCLK),
    .cfg_en       (cfg_en),
    .cfg_wr       (cfg_wr),
    .cfg_inmod    (cfg_inmod),
    .cfg_indiv    (cfg_indiv),
    .fault_clr    (fault_clr),
    .sd_clk_in    (sd_clk_in),
    .detect_err   (detect_err),
    .reg_inmod    (reg_inmod),
    .reg_indiv    (reg_indiv),
    .flt_rstn     (flt_rstn),
    .flt_en       (flt_en),
    .cfg_busy     (cfg_busy),
    .irq_fault    (irq_fault),
    .fault_sticky (fault_sticky),
    .fault_cause  (fault_cause),
    .state        (state)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample point is 1 unit after the edge. The strobe toggles every
  // 12 cycles; a rising edge driven while LOCK is observed will be seen in LOCK.
  task automatic tick();
    @(posedge SYSCLK);
    #1;
    if (state == S_SETTLE) lock_edges = 0;
    if (clk_on != 0) begin
      ph++;
      if (ph == 12) begin
        ph = 0;
        sd_clk_in = ~sd_clk_in;
        if (sd_clk_in && state == S_LOCK) lock_edges++;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== tgt && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(tgt));
  endtask

  task automatic write_cfg(input logic [1:0] m, input logic [3:0] d);
    cfg_inmod = m;
    cfg_indiv = d;
    cfg_wr    = 1'b1;
    cfg_q.push_back('{inmod: m, indiv: d});
  endtask

  task automatic pop_cfg(input string tag);
    cfg_t e;
    if (cfg_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = cfg_q.pop_front();
      chk(tag, {26'd0, reg_inmod, reg_indiv}, {26'd0, e.inmod, e.indiv});
    end
  endtask

  task automatic pop_cause(input string tag);
    logic [1:0] c;
    if (cause_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      c = cause_q.pop_front();
      chk(tag, 32'(fault_cause), 32'(c));
    end
  endtask

  initial begin
    int n;
    int busy_drop;
    int irq_cnt;

    SYSRSTn    = 1'b0;
    cfg_en     = 1'b0;
    cfg_wr     = 1'b0;
    cfg_inmod  = 2'b00;
    cfg_indiv  = 4'd0;
    fault_clr  = 1'b0;
    sd_clk_in  = 1'b0;
    detect_err = 1'b0;

    // Reset state
    #12;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_outs", {19'd0, reg_inmod, reg_indiv, flt_rstn, flt_en, cfg_busy,
                     irq_fault, fault_sticky, fault_cause}, 32'd0);
    #5 SYSRSTn = 1'b1;
    tick();

    // Config write in IDLE, then enable: SWITCH applies mode 3 / div 2
    write_cfg(2'b11, 4'd2);
    tick();
    cfg_wr = 1'b0;
    chk("idle_not_busy", 32'(cfg_busy), 32'd0);
    cfg_en = 1'b1;
    clk_on = 1;
    tick();
    chk("en_to_switch", 32'(state), 32'(S_SWITCH));
    pop_cfg("switch1_reg");
    chk("switch1_busy", 32'(cfg_busy), 32'd1);
    chk("switch1_rstn", 32'(flt_rstn), 32'd0);
    tick();
    chk("settle_entry", 32'(state), 32'(S_SETTLE));
    for (int i = 0; i < 63; i++) tick();
    chk("settle_last", 32'(state), 32'(S_SETTLE));
    tick();
    chk("lock_entry", 32'(state), 32'(S_LOCK));
    n = 0;
    while (state == S_LOCK && n < 1000) begin
      tick();
      n++;
    end
    chk("run1_state", 32'(state), 32'(S_RUN));
    chk("run1_edges", lock_edges, 16);
    chk("run1_flt", {30'd0, flt_rstn, flt_en}, 32'd3);
    chk("run1_busy", 32'(cfg_busy), 32'd0);

    // Reconfigure in RUN: drain 4 cycles, then switch to mode 1
    write_cfg(2'b01, 4'd5);
    tick();
    cfg_wr = 1'b0;
    chk("drain_state", 32'(state), 32'(S_DRAIN));
    chk("drain_flt", {30'd0, flt_rstn, flt_en}, 32'd2);
    chk("drain_busy", 32'(cfg_busy), 32'd1);
    chk("drain_reg_held", 32'(reg_inmod), 32'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("drain_last", 32'(state), 32'(S_DRAIN));
    tick();
    chk("drain_to_switch", 32'(state), 32'(S_SWITCH));
    pop_cfg("switch2_reg");
    busy_drop = 0;
    n = 0;
    while (state != S_RUN && n < 1000) begin
      if (!cfg_busy) busy_drop++;
      tick();
      n++;
    end
    chk("run2_state", 32'(state), 32'(S_RUN));
    chk("busy_until_run", busy_drop, 0);
    chk("run2_edges", lock_edges, 16);

    // Clock error in RUN: fault with cause 01, single irq pulse, clear back to IDLE
    detect_err = 1'b1;
    cause_q.push_back(2'b01);
    tick();
    detect_err = 1'b0;
    chk("fault1_state", 32'(state), 32'(S_FAULT));
    chk("fault1_irq", 32'(irq_fault), 32'd1);
    pop_cause("fault1_cause");
    chk("fault1_flt", {30'd0, flt_rstn, flt_en}, 32'd0);
    chk("fault1_sticky", 32'(fault_sticky), 32'd1);
    tick();
    chk("fault1_irq_once", 32'(irq_fault), 32'd0);
    chk("fault1_hold", 32'(state), 32'(S_FAULT));
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr1_idle", 32'(state), 32'(S_IDLE));
    chk("clr1_sticky", {29'd0, fault_sticky, fault_cause}, 32'd0);
    cfg_q.push_back('{inmod: 2'b01, indiv: 4'd5});
    tick();
    chk("clr1_reswitch", 32'(state), 32'(S_SWITCH));
    pop_cfg("switch3_reg");

    // Dead clock in LOCK: timeout after exactly 4096 LOCK cycles, cause 10
    clk_on    = 0;
    sd_clk_in = 1'b0;
    wait_state(S_LOCK, 200, "tmo_lock_entry");
    n = 0;
    while (state == S_LOCK && n < 5000) begin
      tick();
      n++;
    end
    cause_q.push_back(2'b10);
    chk("tmo_cycles", n, 4096);
    chk("tmo_state", 32'(state), 32'(S_FAULT));
    chk("tmo_irq", 32'(irq_fault), 32'd1);
    pop_cause("tmo_cause");

    // Shadow accepts writes in FAULT; clear and relock with an error mid-lock
    tick();
    write_cfg(2'b10, 4'd7);
    tick();
    cfg_wr    = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr2_idle", 32'(state), 32'(S_IDLE));
    clk_on = 1;
    ph     = 0;
    tick();
    chk("clr2_reswitch", 32'(state), 32'(S_SWITCH));
    pop_cfg("switch4_reg");
    wait_state(S_LOCK, 200, "err_lock_entry");
    n = 0;
    while (lock_edges < 10 && state == S_LOCK && n < 1000) begin
      tick();
      n++;
    end
    chk("err_edges10", lock_edges, 10);
    tick();
    detect_err = 1'b1;
    lock_edges = 0;
    tick();
    detect_err = 1'b0;
    chk("err_still_lock", 32'(state), 32'(S_LOCK));
    n = 0;
    while (state == S_LOCK && n < 1000) begin
      tick();
      n++;
    end
    chk("err_run_state", 32'(state), 32'(S_RUN));
    chk("err_run_edges", lock_edges, 16);

    // Reset during SETTLE clears everything asynchronously, shadow included
    write_cfg(2'b00, 4'd1);
    tick();
    cfg_wr = 1'b0;
    wait_state(S_SWITCH, 20, "rst_path_switch");
    pop_cfg("switch5_reg");
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("rst_pre_settle", 32'(state), 32'(S_SETTLE));
    SYSRSTn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(S_IDLE));
    chk("arst_outs", {19'd0, reg_inmod, reg_indiv, flt_rstn, flt_en, cfg_busy,
                      irq_fault, fault_sticky, fault_cause}, 32'd0);
    tick();
    SYSRSTn = 1'b1;
    cfg_q.push_back('{inmod: 2'b00, indiv: 4'd0});
    tick();
    chk("post_rst_switch", 32'(state), 32'(S_SWITCH));
    pop_cfg("switch6_reg");

    // Permanently dead clock: count fault entries
    clk_on    = 0;
    sd_clk_in = 1'b0;
    irq_cnt   = 0;
`ifdef SDFM_INSEQ_AUTORETRY_EN
    for (int i = 0; i < 19000; i++) begin
      tick();
      if (irq_fault) irq_cnt++;
    end
    chk("retry_irq_count", irq_cnt, 4);
`else
    n = 0;
    while (state != S_FAULT && n < 5000) begin
      tick();
      if (irq_fault) irq_cnt++;
      n++;
    end
    for (int i = 0; i < 600; i++) begin
      tick();
      if (irq_fault) irq_cnt++;
    end
    chk("noretry_irq_count", irq_cnt, 1);
`endif
    chk("dead_stuck_fault", 32'(state), 32'(S_FAULT));
    chk("dead_cause", {29'd0, fault_sticky, fault_cause}, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
